cdb_arbiter: RTL

//   Drives the common data bus (CDB) that the ROB and reservation stations listen to.

---
 rtl/cdb_arbiter_if.sv | 34 +++
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Common data bus interface: execution-unit requests and grants, plus the
// registered broadcast that the ROB and reservation stations listen to.
interface cdb_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32
);

  logic                        Flush;
  logic [NUM_UNITS-1:0]        Unit_valid;
  logic [NUM_UNITS*TAG_W-1:0]  Unit_rd_tag;
  logic [NUM_UNITS*DATA_W-1:0] Unit_data;
  logic [NUM_UNITS-1:0]        Unit_branch;
  logic [NUM_UNITS-1:0]        Unit_branch_taken;
  logic [NUM_UNITS-1:0]        Unit_ready;
  logic                        Cdb_valid;
  logic [TAG_W-1:0]            Cdb_rd_tag;
  logic [DATA_W-1:0]           Cdb_data;
  logic                        Cdb_branch;
  logic                        Cdb_branch_taken;

  // Requester side: execution units and the flush source
  modport master (
    output Flush, Unit_valid, Unit_rd_tag, Unit_data, Unit_branch, Unit_branch_taken,
    input  Unit_ready, Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken
  );

  // Arbiter side: grants requests and drives the broadcast
  modport slave (
    input  Flush, Unit_valid, Unit_rd_tag, Unit_data, Unit_branch, Unit_branch_taken,
    output Unit_ready, Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. One unit is granted per cycle
// (combinationally, from Unit_valid) and its result is broadcast on the
// registered Cdb_* outputs the following cycle. Flush suppresses grants.
module cdb_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  localparam int RR_W = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1;

  logic [RR_W-1:0]      rr;
  logic [RR_W-1:0]      rr_next;
  logic                 grant_found;
  logic [RR_W-1:0]      grant_idx;
  logic [NUM_UNITS-1:0] grant_onehot;
  logic [RR_W:0]        scan_sum;
  logic [RR_W-1:0]      scan_idx;

  logic [TAG_W-1:0]     win_tag;
  logic [DATA_W-1:0]    win_data;
  logic                 win_branch;
  logic                 win_taken;

  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic [DATA_W-1:0]    cdb_data;
  logic                 cdb_branch;
  logic                 cdb_taken;

  // Scan requests starting at rr and wrapping; no grant during reset or flush
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    if (reset && !bus.Flush) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        scan_sum = {1'b0, rr} + (RR_W+1)'(i);
        if (scan_sum >= (RR_W+1)'(NUM_UNITS)) begin
          scan_sum = scan_sum - (RR_W+1)'(NUM_UNITS);
        end
        scan_idx = scan_sum[RR_W-1:0];
        if (!grant_found && bus.Unit_valid[scan_idx]) begin
          grant_found = 1'b1;
          grant_idx   = scan_idx;
        end
      end
    end
  end

  // Decode the winning index into the one-hot ready vector
  always_comb begin
    grant_onehot = '0;
    if (grant_found) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  // Select the winner's payload; taken only counts for real branches
  always_comb begin
    win_tag    = '0;
    win_data   = '0;
    win_branch = 1'b0;
    win_taken  = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant_onehot[i]) begin
        win_tag    = bus.Unit_rd_tag[i*TAG_W +: TAG_W];
        win_data   = bus.Unit_data[i*DATA_W +: DATA_W];
        win_branch = bus.Unit_branch[i];
        win_taken  = bus.Unit_branch[i] & bus.Unit_branch_taken[i];
      end
    end
  end

  // Pointer moves just past the winner; stays put when nothing is granted
  always_comb begin
    rr_next = rr;
    if (grant_found) begin
      if (grant_idx == RR_W'(NUM_UNITS - 1)) begin
        rr_next = '0;
      end else begin
        rr_next = grant_idx + 1'b1;
      end
    end
  end

  // Broadcast register and round-robin pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr         <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      cdb_branch <= 1'b0;
      cdb_taken  <= 1'b0;
    end else begin
      rr        <= rr_next;
      cdb_valid <= grant_found;
      if (grant_found) begin
        cdb_tag    <= win_tag;
        cdb_data   <= win_data;
        cdb_branch <= win_branch;
        cdb_taken  <= win_taken;
      end else begin
        cdb_taken  <= 1'b0;
      end
    end
  end

  assign bus.Unit_ready       = grant_onehot;
  assign bus.Cdb_valid        = cdb_valid;
  assign bus.Cdb_rd_tag       = cdb_tag;
  assign bus.Cdb_data         = cdb_data;
  assign bus.Cdb_branch       = cdb_branch;
  assign bus.Cdb_branch_taken = cdb_taken;

endmodule
